// File: rtl/divider_pkg.sv
// Shared definitions for the sequential divider back end: FSM encoding and default sizes.
package divider_pkg;

  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_CNT_W  = 3;
  localparam int unsigned SUB_CYCLES = DEF_WIDTH;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SUB     = 3'd1,
    CORRECT = 3'd2,
    SHIFT   = 3'd3,
    DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/serial_bit_subtractor.sv
// One-bit full subtractor with a registered borrow; used LSB-first to resolve Q - Q_star.
module serial_bit_subtractor (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic q,
  input  logic s,
  output logic diff_c,
  output logic borrow
);

  assign diff_c = q ^ s ^ borrow;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      borrow <= 1'b0;
    end else if (en) begin
      borrow <= (~q & s) | (~(q ^ s) & borrow);
    end
  end

endmodule

// File: rtl/srt_quotient_finalizer.sv
// Redundant-to-binary quotient conversion, negative-remainder correction and remainder denormalisation.
// Optional quotient overflow flag enabled by defining DIV_QUOTIENT_OVF_EN.
module srt_quotient_finalizer
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH:0]   A_in,
  input  logic [WIDTH-1:0] Q_in,
  input  logic [WIDTH-1:0] Q_star_in,
  input  logic [WIDTH-1:0] M_in,
  input  logic [CNT_W-1:0] shift_cnt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             ovf
);

  localparam int unsigned BIT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned SUB_LAST = WIDTH - 1;

  state_e           state;
  logic [WIDTH:0]   a_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] qs_reg;
  logic [WIDTH-1:0] m_reg;
  logic [CNT_W-1:0] k_reg;
  logic [BIT_W-1:0] bit_cnt;

  logic             sub_clr_c;
  logic             sub_en_c;
  logic             diff_c;
  logic             corr_c;
  logic [WIDTH:0]   a_corr_c;
  logic [WIDTH-1:0] q_corr_c;

  assign sub_clr_c = (state == IDLE) && start;
  assign sub_en_c  = (state == SUB);

`ifdef DIV_QUOTIENT_OVF_EN
  logic b_out;
  logic ovf_pend;
  logic ovf_c;

  serial_bit_subtractor u_sub (
    .clk    (clk),
    .rst    (rst),
    .clr    (sub_clr_c),
    .en     (sub_en_c),
    .q      (q_reg[0]),
    .s      (qs_reg[0]),
    .diff_c (diff_c),
    .borrow (b_out)
  );

  // Negative raw quotient, or the correction decrement wrapping below zero.
  assign ovf_c = b_out | (corr_c & (q_reg == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf      <= 1'b0;
      ovf_pend <= 1'b0;
    end else if (state == CORRECT) begin
      ovf_pend <= ovf_c;
      if (k_reg == '0) ovf <= ovf_c;
    end else if (state == SHIFT && k_reg == CNT_W'(1)) begin
      ovf <= ovf_pend;
    end
  end
`else
  logic b_out_unused;

  serial_bit_subtractor u_sub (
    .clk    (clk),
    .rst    (rst),
    .clr    (sub_clr_c),
    .en     (sub_en_c),
    .q      (q_reg[0]),
    .s      (qs_reg[0]),
    .diff_c (diff_c),
    .borrow (b_out_unused)
  );

  assign ovf = 1'b0;
`endif

  assign corr_c   = a_reg[WIDTH];
  assign a_corr_c = corr_c ? (a_reg + {1'b0, m_reg}) : a_reg;
  assign q_corr_c = corr_c ? (q_reg - WIDTH'(1)) : q_reg;

  // Control FSM; results are loaded on the edge that enters DONE so they are valid with the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      q_reg     <= '0;
      qs_reg    <= '0;
      m_reg     <= '0;
      k_reg     <= '0;
      bit_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg   <= A_in;
            q_reg   <= Q_in;
            qs_reg  <= Q_star_in;
            m_reg   <= M_in;
            k_reg   <= shift_cnt;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= SUB;
          end
        end
        SUB: begin
          q_reg   <= {diff_c, q_reg[WIDTH-1:1]};
          qs_reg  <= qs_reg >> 1;
          bit_cnt <= bit_cnt + BIT_W'(1);
          if (bit_cnt == BIT_W'(SUB_LAST)) state <= CORRECT;
        end
        CORRECT: begin
          a_reg <= a_corr_c;
          q_reg <= q_corr_c;
          if (k_reg == '0) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= q_corr_c;
            remainder <= a_corr_c[WIDTH-1:0];
          end else begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          a_reg <= a_reg >> 1;
          k_reg <= k_reg - CNT_W'(1);
          if (k_reg == CNT_W'(1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= q_reg;
            remainder <= a_reg[WIDTH:1];
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_srt_quotient_finalizer.sv
// Scoreboard bench for srt_quotient_finalizer (default WIDTH=8, CNT_W=3).
module tb_srt_quotient_finalizer;

  localparam int W  = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W:0]    A_in;
  logic [W-1:0]  Q_in;
  logic [W-1:0]  Q_star_in;
  logic [W-1:0]  M_in;
  logic [CW-1:0] shift_cnt;
  logic          busy;
  logic          done;
  logic [W-1:0]  quotient;
  logic [W-1:0]  remainder;
  logic          ovf;

  srt_quotient_finalizer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .A_in      (A_in),
    .Q_in      (Q_in),
    .Q_star_in (Q_star_in),
    .M_in      (M_in),
    .shift_cnt (shift_cnt),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         ovf;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   start_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W:0] a, input logic [W-1:0] q,
                                 input logic [W-1:0] qs, input logic [W-1:0] m,
                                 input logic [CW-1:0] k);
    exp_t         e;
    logic [W-1:0] d;
    logic [W:0]   aa;
    logic         b;
    logic         wrap;
    d    = q - qs;
    b    = (q < qs);
    aa   = a;
    wrap = 1'b0;
    if (a[W]) begin
      aa   = a + {1'b0, m};
      wrap = (d == '0);
      d    = d - 8'd1;
    end
    e.q = d;
    e.r = W'(aa >> k);
`ifdef DIV_QUOTIENT_OVF_EN
    e.ovf = b | wrap;
`else
    e.ovf = 1'b0;
`endif
    e.lat = W + 2 + int'(k);
    return e;
  endfunction

  // Called at a negedge while the DUT is idle; start is sampled on the following posedge.
  task automatic launch(input logic [W:0] a, input logic [W-1:0] q, input logic [W-1:0] qs,
                        input logic [W-1:0] m, input logic [CW-1:0] k);
    sb.push_back(model(a, q, qs, m, k));
    A_in = a; Q_in = q; Q_star_in = qs; M_in = m; shift_cnt = k;
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for done, checking busy on the way; optionally pulses a junk start at cycle 3.
  task automatic wait_result(input string tag, input bit inject);
    exp_t e;
    int   n;
    bit   seen;
    seen = 1'b0;
    for (n = 0; n < 40 && !seen; n++) begin
      if (done) begin
        seen = 1'b1;
        e = sb.pop_front();
        check_eq({tag, "_quotient"}, 32'(quotient), 32'(e.q));
        check_eq({tag, "_remainder"}, 32'(remainder), 32'(e.r));
        check_eq({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
        check_eq({tag, "_latency"}, 32'(cyc - start_cyc), 32'(e.lat));
        check_eq({tag, "_busy_done"}, 32'(busy), 32'd0);
      end else begin
        if (!busy) check_eq({tag, "_busy_early"}, 32'(busy), 32'd1);
        if (inject && (cyc - start_cyc) == 3) begin
          A_in = 9'h1AA; Q_in = 8'hFF; Q_star_in = 8'h00; M_in = 8'hFF; shift_cnt = 3'd5;
          start = 1'b1;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (!seen) begin
      check_eq({tag, "_timeout"}, 32'd0, 32'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end
  endtask

  initial begin
    logic [W-1:0] m;
    logic [W:0]   a;
    rst = 1'b1; start = 1'b0;
    A_in = '0; Q_in = '0; Q_star_in = '0; M_in = '0; shift_cnt = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_quotient", 32'(quotient), 32'd0);
    check_eq("rst_remainder", 32'(remainder), 32'd0);
    check_eq("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    launch(9'h003, 8'h5A, 8'h14, 8'h80, 3'd0);
    wait_result("t1", 1'b0);
    @(negedge clk);
    launch(9'h1F0, 8'h10, 8'h02, 8'h20, 3'd2);
    wait_result("t2", 1'b0);
    @(negedge clk);
    launch(9'h000, 8'h00, 8'h01, 8'h80, 3'd0);
    wait_result("t3", 1'b0);
    @(negedge clk);
    launch(9'h003, 8'h5A, 8'h14, 8'h80, 3'd0);
    wait_result("t4", 1'b1);
    @(negedge clk);

    // Reset in the middle of SUB.
    launch(9'h1F0, 8'h10, 8'h02, 8'h20, 3'd2);
    while ((cyc - start_cyc) < 4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t5_busy", 32'(busy), 32'd0);
    check_eq("t5_quotient", 32'(quotient), 32'd0);
    check_eq("t5_remainder", 32'(remainder), 32'd0);
    check_eq("t5_done", 32'(done), 32'd0);
    void'(sb.pop_back());
    rst = 1'b0;
    @(negedge clk);
    launch(9'h003, 8'h5A, 8'h14, 8'h80, 3'd0);
    wait_result("t5", 1'b0);
    @(negedge clk);

    // Maximum shift, then a start in the very next IDLE cycle.
    launch(9'h080, 8'h03, 8'h00, 8'h80, 3'd7);
    wait_result("t6", 1'b0);
    @(negedge clk);
    launch(9'h1F0, 8'h10, 8'h02, 8'h20, 3'd2);
    wait_result("t6_b2b", 1'b0);
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      m = W'($urandom_range(128, 255));
      if ($urandom_range(0, 1) == 1) a = 9'(512 - int'($urandom_range(1, int'(m))));
      else a = 9'($urandom_range(0, int'(m) - 1));
      launch(a, W'($urandom), W'($urandom), m, CW'($urandom_range(0, 7)));
      wait_result("rand", 1'b0);
      @(negedge clk);
    end

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
